tcm_arbiter: RTL and testbench

- Shares one single-port TCM between the core's instruction-fetch port (read-only) and data port (read/write).
- Sits between the fetch/LSU stages and the TCM macro.
- Issues at most one TCM access per cycle, tags it with its owner, and routes the one-cycle-later TCM ack/data back to that owner.
- Uses fixed data-over-instruction priority with a starvation guard; back-to-back issue is allowed, so throughput is one access per cycle.

---
 rtl/tcm_arb_pkg.sv | 17 +
 rtl/tcm_arbiter_if.sv | 48 ++++
 rtl/tcm_arb_sel.sv | 31 +++
 rtl/tcm_arbiter.sv | 124 ++++++++++++
 tb/tb_tcm_arbiter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/tcm_arb_pkg.sv
// Shared types and widths for the TCM arbiter.
package tcm_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IBUS = 2'd1,
        OWN_DBUS = 2'd2
    } owner_t;

    localparam int TCM_DATA_W = 32;
    localparam int TCM_BE_W   = 4;

    // One-hot grant vector bit positions.
    localparam int GNT_IBUS = 0;
    localparam int GNT_DBUS = 1;

endpackage

// File: rtl/tcm_arbiter_if.sv
// Bus bundle between fetch/LSU, the TCM arbiter and the TCM macro.
// Signal names are from the arbiter's point of view: i_* enter the arbiter,
// o_* leave it. The slave modport is the arbiter, master is its environment.
interface tcm_arbiter_if
    import tcm_arb_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 8
);
    logic                         i_ibus_req;
    logic [MEM_ADDR_WIDTH+1:2]    i_ibus_addr;
    logic                         o_ibus_gnt;
    logic                         o_ibus_ack;
    logic [TCM_DATA_W-1:0]        o_ibus_data;

    logic                         i_dbus_req;
    logic [MEM_ADDR_WIDTH+1:2]    i_dbus_addr;
    logic [TCM_BE_W-1:0]          i_dbus_write;
    logic [TCM_DATA_W-1:0]        i_dbus_data;
    logic                         o_dbus_gnt;
    logic                         o_dbus_ack;
    logic [TCM_DATA_W-1:0]        o_dbus_data;

    logic                         o_tcm_sel;
    logic [MEM_ADDR_WIDTH+1:2]    o_tcm_addr;
    logic [TCM_BE_W-1:0]          o_tcm_write;
    logic [TCM_DATA_W-1:0]        o_tcm_data;
    logic                         i_tcm_ack;
    logic [TCM_DATA_W-1:0]        i_tcm_data;

    modport slave (
        input  i_ibus_req, i_ibus_addr,
        output o_ibus_gnt, o_ibus_ack, o_ibus_data,
        input  i_dbus_req, i_dbus_addr, i_dbus_write, i_dbus_data,
        output o_dbus_gnt, o_dbus_ack, o_dbus_data,
        output o_tcm_sel, o_tcm_addr, o_tcm_write, o_tcm_data,
        input  i_tcm_ack, i_tcm_data
    );

    modport master (
        output i_ibus_req, i_ibus_addr,
        input  o_ibus_gnt, o_ibus_ack, o_ibus_data,
        output i_dbus_req, i_dbus_addr, i_dbus_write, i_dbus_data,
        input  o_dbus_gnt, o_dbus_ack, o_dbus_data,
        input  o_tcm_sel, o_tcm_addr, o_tcm_write, o_tcm_data,
        output i_tcm_ack, i_tcm_data
    );

endinterface

// File: rtl/tcm_arb_sel.sv
// Pure grant selection for the TCM arbiter. i_ibus_prio decides who wins
// when both ports request (starvation hit, or round-robin turn).
module tcm_arb_sel
    import tcm_arb_pkg::*;
(
    input  logic       i_reset,
    input  logic       i_ibus_req,
    input  logic       i_dbus_req,
    input  logic       i_ibus_prio,
    output logic [1:0] o_gnt
);

    // One-hot grant; nothing is granted while reset is held.
    always_comb begin
        o_gnt = 2'b00;
        if (!i_reset) begin
            if (i_ibus_req && i_dbus_req) begin
                if (i_ibus_prio) begin
                    o_gnt[GNT_IBUS] = 1'b1;
                end else begin
                    o_gnt[GNT_DBUS] = 1'b1;
                end
            end else if (i_ibus_req) begin
                o_gnt[GNT_IBUS] = 1'b1;
            end else if (i_dbus_req) begin
                o_gnt[GNT_DBUS] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tcm_arbiter.sv
// Shares one single-port TCM between instruction fetch and the data port.
// One access per cycle, response returned one cycle later to its owner.
// Build option TCM_ARB_RR_EN: alternate conflict winners instead of fixed
// data priority with a starvation guard.
module tcm_arbiter
    import tcm_arb_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 8
`ifndef TCM_ARB_RR_EN
    ,
    parameter int STARVE_LIMIT   = 4
`endif
)(
    input  logic               i_clk,
    input  logic               i_reset,
    tcm_arbiter_if.slave       bus,
    output logic [31:0]        o_conflicts
);

    logic [1:0]                w_gnt;
    logic                      w_ibus_gnt;
    logic                      w_dbus_gnt;
    logic                      w_both_req;
    logic                      w_ibus_prio;
    logic [MEM_ADDR_WIDTH-1:0] w_tcm_addr;
    owner_t                    r_owner;
    logic [31:0]               r_conflicts;

    assign w_both_req = bus.i_ibus_req & bus.i_dbus_req;

`ifdef TCM_ARB_RR_EN
    // r_last = 1 means dbus won the previous conflict, so ibus goes next.
    logic r_last;

    assign w_ibus_prio = r_last;

    // Record the winner of every conflict to alternate the next one.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last <= 1'b0;
        end else if (w_both_req) begin
            r_last <= w_dbus_gnt;
        end
    end
`else
    localparam logic [3:0] LP_STARVE_LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] r_starve;

    assign w_ibus_prio = (r_starve == LP_STARVE_LIMIT);

    // Count consecutive conflicts lost by ibus, saturating at the limit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_starve <= 4'd0;
        end else if (!bus.i_ibus_req || w_ibus_gnt) begin
            r_starve <= 4'd0;
        end else if (w_both_req && w_dbus_gnt && (r_starve != LP_STARVE_LIMIT)) begin
            r_starve <= r_starve + 4'd1;
        end
    end
`endif

    tcm_arb_sel u_sel (
        .i_reset     (i_reset),
        .i_ibus_req  (bus.i_ibus_req),
        .i_dbus_req  (bus.i_dbus_req),
        .i_ibus_prio (w_ibus_prio),
        .o_gnt       (w_gnt)
    );

    assign w_ibus_gnt     = w_gnt[GNT_IBUS];
    assign w_dbus_gnt     = w_gnt[GNT_DBUS];
    assign bus.o_ibus_gnt = w_ibus_gnt;
    assign bus.o_dbus_gnt = w_dbus_gnt;

    // TCM request mux: write payload only ever comes from a dbus grant.
    always_comb begin
        w_tcm_addr      = '0;
        bus.o_tcm_write = '0;
        bus.o_tcm_data  = '0;
        if (w_dbus_gnt) begin
            w_tcm_addr      = bus.i_dbus_addr;
            bus.o_tcm_write = bus.i_dbus_write;
            bus.o_tcm_data  = bus.i_dbus_data;
        end else if (w_ibus_gnt) begin
            w_tcm_addr      = bus.i_ibus_addr;
        end
    end

    assign bus.o_tcm_sel  = w_ibus_gnt | w_dbus_gnt;
    assign bus.o_tcm_addr = w_tcm_addr;

    // Remember who owns the access issued this cycle for next-cycle routing.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_owner <= OWN_NONE;
        end else if (w_ibus_gnt) begin
            r_owner <= OWN_IBUS;
        end else if (w_dbus_gnt) begin
            r_owner <= OWN_DBUS;
        end else begin
            r_owner <= OWN_NONE;
        end
    end

    // Reset also masks the ack, so a response in flight at reset is dropped.
    assign bus.o_ibus_ack  = bus.i_tcm_ack & (r_owner == OWN_IBUS) & ~i_reset;
    assign bus.o_dbus_ack  = bus.i_tcm_ack & (r_owner == OWN_DBUS) & ~i_reset;
    assign bus.o_ibus_data = bus.i_tcm_data;
    assign bus.o_dbus_data = bus.i_tcm_data;

    // Free-running conflict counter, wraps naturally.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_conflicts <= 32'd0;
        end else if (w_both_req) begin
            r_conflicts <= r_conflicts + 32'd1;
        end
    end

    assign o_conflicts = r_conflicts;

endmodule

// File: tb/tb_tcm_arbiter.sv
// Directed bench for tcm_arbiter with a small behavioural TCM.
module tb_tcm_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] conflicts;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    tcm_arbiter_if #(.MEM_ADDR_WIDTH(8)) bus ();

    tcm_arbiter #(.MEM_ADDR_WIDTH(8)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .bus         (bus),
        .o_conflicts (conflicts)
    );

    // TCM model: preloaded mem[i] = 0x1000_0000 + i, one-cycle ack/data.
    logic [31:0] mem [0:255];
    logic        m_ack  = 1'b0;
    logic [31:0] m_data = 32'd0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    end

    always @(posedge clk) begin
        m_ack <= bus.o_tcm_sel;
        if (bus.o_tcm_sel) begin
            m_data <= mem[bus.o_tcm_addr];
            for (int b = 0; b < 4; b++) begin
                if (bus.o_tcm_write[b]) mem[bus.o_tcm_addr][8*b +: 8] <= bus.o_tcm_data[8*b +: 8];
            end
        end
    end

    assign bus.i_tcm_ack  = m_ack;
    assign bus.i_tcm_data = m_data;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic ireq, input logic [7:0] iaddr,
                       input logic dreq, input logic [7:0] daddr,
                       input logic [3:0] dwr, input logic [31:0] ddata);
        bus.i_ibus_req   = ireq;
        bus.i_ibus_addr  = iaddr;
        bus.i_dbus_req   = dreq;
        bus.i_dbus_addr  = daddr;
        bus.i_dbus_write = dwr;
        bus.i_dbus_data  = ddata;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    logic [9:0] exp_d;

    initial begin
        // Reset with both ports requesting: no grants, counter cleared.
        rst = 1'b1;
        drv(1, 8'h10, 1, 8'h20, 4'h0, 32'h0);
        next_cyc();
        @(negedge clk);
        chk("rst_sel", bus.o_tcm_sel, 1'b0);
        chk("rst_gnt", {bus.o_ibus_gnt, bus.o_dbus_gnt}, 2'b00);
        chk("rst_ack", {bus.o_ibus_ack, bus.o_dbus_ack}, 2'b00);
        chk("rst_cnt", conflicts, 32'd0);
        next_cyc();
        rst = 1'b0;
        drv(0, 8'h00, 0, 8'h00, 4'h0, 32'h0);
        next_cyc();

        // ibus only, addr 0x10, three cycles.
        for (int k = 0; k < 5; k++) begin
            drv(k < 3, 8'h10, 0, 8'h00, 4'h0, 32'h0);
            @(negedge clk);
            if (k < 3) begin
                chk("ib_gnt", bus.o_ibus_gnt, 1'b1);
                chk("ib_addr", bus.o_tcm_addr, 8'h10);
                chk("ib_wr", bus.o_tcm_write, 4'h0);
            end
            chk("ib_ack", bus.o_ibus_ack, (k >= 1 && k <= 3));
            if (k >= 1 && k <= 3) chk("ib_data", bus.o_ibus_data, 32'h1000_0010);
            chk("ib_dack", bus.o_dbus_ack, 1'b0);
            next_cyc();
        end

        // Both ports continuously requesting.
`ifdef TCM_ARB_RR_EN
        exp_d = 10'b0101010101;
`else
        exp_d = 10'b0111101111;
`endif
        for (int k = 0; k < 10; k++) begin
            drv(1, 8'h30, 1, 8'h40, 4'h0, 32'h0);
            @(negedge clk);
            chk("cf_dgnt", bus.o_dbus_gnt, exp_d[k]);
            chk("cf_ignt", bus.o_ibus_gnt, !exp_d[k]);
            chk("cf_cnt", conflicts, 32'(k));
            if (k > 0) chk("cf_dack", bus.o_dbus_ack, exp_d[k-1]);
            next_cyc();
        end
        drv(0, 8'h00, 0, 8'h00, 4'h0, 32'h0);
        @(negedge clk);
        chk("cf_cnt_end", conflicts, 32'd10);
        next_cyc();

        // dbus write 0xDEADBEEF be=0011 to 0x05, then read back.
        drv(0, 8'h00, 1, 8'h05, 4'b0011, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("wr_gnt", bus.o_dbus_gnt, 1'b1);
        chk("wr_be", bus.o_tcm_write, 4'b0011);
        chk("wr_data", bus.o_tcm_data, 32'hDEAD_BEEF);
        chk("wr_addr", bus.o_tcm_addr, 8'h05);
        next_cyc();
        drv(0, 8'h00, 1, 8'h05, 4'b0000, 32'h0);
        @(negedge clk);
        chk("rd_be", bus.o_tcm_write, 4'b0000);
        chk("wr_ack", bus.o_dbus_ack, 1'b1);
        next_cyc();
        drv(0, 8'h00, 0, 8'h00, 4'h0, 32'h0);
        @(negedge clk);
        chk("rd_ack", bus.o_dbus_ack, 1'b1);
        chk("rd_data", bus.o_dbus_data, 32'h1000_BEEF);
        chk("rd_iack", bus.o_ibus_ack, 1'b0);
        next_cyc();

        // ibus stream with one injected dbus request.
        for (int k = 0; k < 4; k++) begin
            drv(1, 8'h20, k == 1, 8'h07, 4'h0, 32'h0);
            @(negedge clk);
            chk("inj_ignt", bus.o_ibus_gnt, k != 1);
            chk("inj_dgnt", bus.o_dbus_gnt, k == 1);
`ifndef TCM_ARB_RR_EN
            if (k == 2) chk("inj_starve1", dut.r_starve, 4'd1);
            if (k == 3) chk("inj_starve0", dut.r_starve, 4'd0);
`endif
            next_cyc();
        end
        drv(0, 8'h00, 0, 8'h00, 4'h0, 32'h0);
        @(negedge clk);
        chk("inj_cnt", conflicts, 32'd11);
        next_cyc();

        // Reset in the cycle after an ibus grant drops its response.
        drv(1, 8'h10, 0, 8'h00, 4'h0, 32'h0);
        @(negedge clk);
        chk("rs_gnt", bus.o_ibus_gnt, 1'b1);
        next_cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("rs_ack", bus.o_ibus_ack, 1'b0);
        chk("rs_sel", bus.o_tcm_sel, 1'b0);
        chk("rs_ignt", bus.o_ibus_gnt, 1'b0);
        next_cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rs_cnt", conflicts, 32'd0);
        chk("rs_first_gnt", bus.o_ibus_gnt, 1'b1);
        chk("rs_ack_none", bus.o_ibus_ack, 1'b0);
        next_cyc();
        drv(0, 8'h00, 0, 8'h00, 4'h0, 32'h0);
        @(negedge clk);
        chk("rs_ack_after", bus.o_ibus_ack, 1'b1);
        chk("rs_data_after", bus.o_ibus_data, 32'h1000_0010);
        next_cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
